cpu_mul_pipeline: RTL and testbench

//  Execute-side multiplier pipeline: accepts operand/destination issues from the execute stage
//  (write-enable from decode), carries them through MUL_STAGES registered stages and presents
//  the result to writeback with a valid/ready handshake.

---
 rtl/cpu_mul_pipeline.sv | 103 ++++++++++
 tb/tb_cpu_mul_pipeline.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mul_pipeline.sv
// Execute-side multiplier pipeline: MUL_STAGES lock-step stages with valid/ready writeback and hazard lookup.
// Optional build macro CPU_MUL_OVERFLOW_EN adds wb_overflow (any upper product bit set).
module cpu_mul_pipeline #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REG_ID_WIDTH = 5,
  parameter int unsigned MUL_STAGES   = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [REG_ID_WIDTH-1:0] issue_rd_id,
  input  logic [DATA_WIDTH-1:0]   issue_ra_data,
  input  logic [DATA_WIDTH-1:0]   issue_rb_data,
  input  logic                    flush,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [REG_ID_WIDTH-1:0] wb_rd_id,
  output logic [DATA_WIDTH-1:0]   wb_data,
  input  logic [REG_ID_WIDTH-1:0] hz_rd_id,
  output logic                    hz_hit,
  output logic                    busy
`ifdef CPU_MUL_OVERFLOW_EN
  ,
  output logic                    wb_overflow
`endif
);

  localparam int unsigned LAST = MUL_STAGES - 1;

  logic [MUL_STAGES-1:0]                   stg_valid;
  logic [MUL_STAGES-1:0][REG_ID_WIDTH-1:0] stg_rd;
  logic [MUL_STAGES-1:0][DATA_WIDTH-1:0]   stg_data;
  logic [DATA_WIDTH-1:0]                   s0_data_c;
  logic                                    advance_c;

`ifdef CPU_MUL_OVERFLOW_EN
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  logic [PROD_W-1:0]     product_c;
  logic                  s0_ovf_c;
  logic [MUL_STAGES-1:0] stg_ovf;

  // Full-width product; only the overflow summary of the upper half is carried.
  assign product_c = PROD_W'(issue_ra_data) * PROD_W'(issue_rb_data);
  assign s0_data_c = product_c[DATA_WIDTH-1:0];
  assign s0_ovf_c  = |product_c[PROD_W-1:DATA_WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stg_ovf <= '0;
    end else if (!flush && advance_c) begin
      stg_ovf[0] <= s0_ovf_c;
      for (int unsigned k = 1; k < MUL_STAGES; k++) begin
        stg_ovf[k] <= stg_ovf[k-1];
      end
    end
  end

  assign wb_overflow = stg_ovf[LAST];
`else
  assign s0_data_c = issue_ra_data * issue_rb_data;
`endif

  // The whole pipe moves together whenever the output slot is empty or being drained.
  assign advance_c   = ~stg_valid[LAST] | wb_ready;
  assign issue_ready = advance_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stg_valid <= '0;
      stg_rd    <= '0;
      stg_data  <= '0;
    end else if (flush) begin
      stg_valid <= '0;
    end else if (advance_c) begin
      stg_valid[0] <= issue_valid;
      stg_rd[0]    <= issue_rd_id;
      stg_data[0]  <= s0_data_c;
      for (int unsigned k = 1; k < MUL_STAGES; k++) begin
        stg_valid[k] <= stg_valid[k-1];
        stg_rd[k]    <= stg_rd[k-1];
        stg_data[k]  <= stg_data[k-1];
      end
    end
  end

  assign wb_valid = stg_valid[LAST];
  assign wb_rd_id = stg_rd[LAST];
  assign wb_data  = stg_data[LAST];
  assign busy     = |stg_valid;

  // Destination lookup over every in-flight entry, including the one presented to writeback.
  always_comb begin
    hz_hit = 1'b0;
    for (int unsigned k = 0; k < MUL_STAGES; k++) begin
      if (stg_valid[k] && (stg_rd[k] == hz_rd_id)) begin
        hz_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mul_pipeline.sv
// Directed self-checking bench for cpu_mul_pipeline (default parameters, 4 stages).
module tb_cpu_mul_pipeline;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned NS = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          issue_valid;
  logic          issue_ready;
  logic [RW-1:0] issue_rd_id;
  logic [DW-1:0] issue_ra_data;
  logic [DW-1:0] issue_rb_data;
  logic          flush;
  logic          wb_valid;
  logic          wb_ready;
  logic [RW-1:0] wb_rd_id;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] hz_rd_id;
  logic          hz_hit;
  logic          busy;
`ifdef CPU_MUL_OVERFLOW_EN
  logic          wb_overflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cpu_mul_pipeline #(.DATA_WIDTH(DW), .REG_ID_WIDTH(RW), .MUL_STAGES(NS)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rd_id   (issue_rd_id),
    .issue_ra_data (issue_ra_data),
    .issue_rb_data (issue_rb_data),
    .flush         (flush),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_rd_id      (wb_rd_id),
    .wb_data       (wb_data),
    .hz_rd_id      (hz_rd_id),
    .hz_hit        (hz_hit),
    .busy          (busy)
`ifdef CPU_MUL_OVERFLOW_EN
    ,
    .wb_overflow   (wb_overflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_issue(input logic v, input logic [RW-1:0] rd,
                             input logic [DW-1:0] ra, input logic [DW-1:0] rb);
    issue_valid   = v;
    issue_rd_id   = rd;
    issue_ra_data = ra;
    issue_rb_data = rb;
  endtask

  logic [DW-1:0] stream_exp [8] = '{32'd3, 32'd8, 32'd15, 32'd24, 32'd35, 32'd48, 32'd63, 32'd80};
  logic [DW-1:0] bp_exp [5]     = '{32'd20, 32'd22, 32'd24, 32'd26, 32'd28};

  initial begin
    int got_n;
    int first_cyc;
    int last_cyc;
    logic any_hit;
    logic seen;

    reset_n = 1'b0;
    flush = 1'b0;
    wb_ready = 1'b1;
    hz_rd_id = '0;
    drive_issue(1'b0, '0, '0, '0);
    repeat (2) tick();

    // Reset state
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_issue_ready", 64'(issue_ready), 64'd1);
    check("rst_wb_rd_id", 64'(wb_rd_id), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    any_hit = 1'b0;
    for (int i = 0; i < 32; i++) begin
      hz_rd_id = RW'(i);
      #1;
      any_hit = any_hit | hz_hit;
    end
    check("rst_hz_hit_any", 64'(any_hit), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single issue 7*6 -> rd 3
    hz_rd_id = 5'd3;
    drive_issue(1'b1, 5'd3, 32'd7, 32'd6);
    #1;
    check("single_hz_excl_issue", 64'(hz_hit), 64'd0);
    tick();
    drive_issue(1'b0, '0, '0, '0);
    for (int i = 0; i < int'(NS) - 1; i++) begin
      check("single_inflight_hz", 64'(hz_hit), 64'd1);
      check("single_inflight_wbv", 64'(wb_valid), 64'd0);
      tick();
    end
    check("single_wb_valid", 64'(wb_valid), 64'd1);
    check("single_wb_data", 64'(wb_data), 64'd42);
    check("single_wb_rd", 64'(wb_rd_id), 64'd3);
    check("single_wb_hz", 64'(hz_hit), 64'd1);
    tick();
    check("single_retired_valid", 64'(wb_valid), 64'd0);
    check("single_retired_hz", 64'(hz_hit), 64'd0);
    check("single_retired_busy", 64'(busy), 64'd0);

    // Stream of 8: ra=i+1, rb=i+3, rd=i+1
    got_n = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) drive_issue(1'b1, RW'(c + 1), DW'(c + 1), DW'(c + 3));
      else drive_issue(1'b0, '0, '0, '0);
      if (c < 8) check("stream_issue_ready", 64'(issue_ready), 64'd1);
      tick();
      if (wb_valid) begin
        if (got_n < 8) begin
          check("stream_data", 64'(wb_data), 64'(stream_exp[got_n]));
          check("stream_rd", 64'(wb_rd_id), 64'(got_n + 1));
        end
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got_n++;
      end
    end
    check("stream_count", 64'(got_n), 64'd8);
    check("stream_first_latency", 64'(first_cyc), 64'(NS - 1));
    check("stream_no_gaps", 64'(last_cyc - first_cyc), 64'd7);

    // Backpressure: fill with wb_ready=0, hold 3 cycles with a pending issue
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_issue(1'b1, RW'(8 + i), DW'(10 + i), 32'd2);
      tick();
    end
    drive_issue(1'b1, 5'd12, 32'd14, 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("bp_wb_valid", 64'(wb_valid), 64'd1);
      check("bp_wb_data", 64'(wb_data), 64'd20);
      check("bp_wb_rd", 64'(wb_rd_id), 64'd8);
      check("bp_issue_ready", 64'(issue_ready), 64'd0);
      hz_rd_id = 5'd12;
      #1;
      check("bp_hz_pending", 64'(hz_hit), 64'd0);
      hz_rd_id = 5'd11;
      #1;
      check("bp_hz_inflight", 64'(hz_hit), 64'd1);
      tick();
    end
    wb_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(issue_ready), 64'd1);
    got_n = 0;
    if (wb_valid) begin
      check("bp_drain_data", 64'(wb_data), 64'(bp_exp[0]));
      got_n++;
    end
    tick();
    drive_issue(1'b0, '0, '0, '0);
    if (wb_valid) begin
      if (got_n < 5) begin
        check("bp_drain_data", 64'(wb_data), 64'(bp_exp[got_n]));
        check("bp_drain_rd", 64'(wb_rd_id), 64'(8 + got_n));
      end
      got_n++;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wb_valid) begin
        if (got_n < 5) begin
          check("bp_drain_data", 64'(wb_data), 64'(bp_exp[got_n]));
          check("bp_drain_rd", 64'(wb_rd_id), 64'(8 + got_n));
        end
        got_n++;
      end
    end
    check("bp_drain_count", 64'(got_n), 64'd5);

    // Flush with full pipe plus simultaneous issue
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_issue(1'b1, RW'(20 + i), DW'(i + 1), 32'd5);
      tick();
    end
    check("flush_pre_full", 64'(wb_valid), 64'd1);
    flush = 1'b1;
    wb_ready = 1'b1;
    drive_issue(1'b1, 5'd24, 32'd9, 32'd9);
    tick();
    flush = 1'b0;
    drive_issue(1'b0, '0, '0, '0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_wb_valid", 64'(wb_valid), 64'd0);
    hz_rd_id = 5'd24;
    #1;
    check("flush_hz_dropped", 64'(hz_hit), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | wb_valid;
    end
    check("flush_no_result", 64'(seen), 64'd0);

    // Asynchronous reset mid-flight
    drive_issue(1'b1, 5'd5, 32'd3, 32'd3);
    tick();
    drive_issue(1'b0, '0, '0, '0);
    check("arst_pre_busy", 64'(busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Truncation / overflow vectors
    drive_issue(1'b1, 5'd1, 32'hFFFF_FFFF, 32'd2);
    tick();
    drive_issue(1'b1, 5'd2, 32'h0001_0000, 32'h0000_FFFF);
    tick();
    drive_issue(1'b0, '0, '0, '0);
    tick();
    tick();
    check("ovf_a_valid", 64'(wb_valid), 64'd1);
    check("ovf_a_data", 64'(wb_data), 64'hFFFF_FFFE);
`ifdef CPU_MUL_OVERFLOW_EN
    check("ovf_a_flag", 64'(wb_overflow), 64'd1);
`endif
    tick();
    check("ovf_b_valid", 64'(wb_valid), 64'd1);
    check("ovf_b_data", 64'(wb_data), 64'hFFFF_0000);
`ifdef CPU_MUL_OVERFLOW_EN
    check("ovf_b_flag", 64'(wb_overflow), 64'd0);
`endif
    tick();
    check("ovf_done_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
